traffic_chk: RTL and testbench

//  H2C-direction counterpart of traffic_gen: sinks a streaming packet interface (valid/ready/data/last/qid),

---
 rtl/traffic_chk.sv | 220 ++++++++++++++++++++++
 tb/tb_traffic_chk.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_chk.sv
`default_nettype none
// ============================================================================
// Module      : traffic_chk
// Description : Streaming packet sink that checks the deterministic test
//               pattern, beat count and queue rotation of every packet.
// Revision    : 1.0  initial release
// ============================================================================
module traffic_chk #(
    parameter int TX_LEN        = 512,
    parameter int MAX_ETH_FRAME = 4096,
    parameter int QID_W         = 11
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic [31:0]       control_reg,
    input  logic [15:0]       txr_size,
    input  logic [31:0]       num_pkt,
    input  logic [QID_W-1:0]  qid,
    input  logic [QID_W-1:0]  num_queue,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [TX_LEN-1:0] tx_data,
    input  logic              tx_last,
    input  logic [QID_W-1:0]  tx_qid,
    output logic              busy,
    output logic              done,
    output logic [31:0]       pkt_count,
    output logic [31:0]       err_count,
    output logic [3:0]        err_flags,
    output logic [31:0]       cycles_taken
);

    localparam int          c_BYTES = TX_LEN / 8;
    localparam int          c_LANES = TX_LEN / 32;
    localparam logic [15:0] c_LANES16 = 16'(c_LANES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_tx_ready;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_pkt_count;
    logic [31:0]        r_err_count;
    logic [3:0]         r_err_flags;
    logic [31:0]        r_cycles;
    logic               r_started;

    logic [15:0]        r_txr_size;
    logic [15:0]        r_last_beat;
    logic [31:0]        r_num_pkt;
    logic [QID_W-1:0]   r_qid;
    logic [QID_W-1:0]   r_num_queue;

    logic [15:0]        r_beat;
    logic               r_discard;
    logic               r_pkt_err;
    logic [15:0]        r_pkt_idx;
    logic [QID_W-1:0]   r_q_off;

    logic               w_start;
    logic               w_clear;
    logic               w_cfg_ok;
    logic [15:0]        w_beats_exp;
    logic               w_acc;
    logic [c_LANES-1:0] w_lane_err;
    logic               w_qid_err;
    logic               w_short;
    logic               w_long;
    logic [3:0]         w_beat_errs;
    logic               w_pkt_bad;
    logic [31:0]        w_pkt_next;
    logic [QID_W-1:0]   w_q_off_inc;
    logic               w_unused;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign w_start  = control_reg[0];
    assign w_clear  = control_reg[1];
    assign w_unused = ^control_reg[31:2];

    assign w_cfg_ok = (txr_size != 16'd0)
                   && ({16'd0, txr_size} <= 32'(MAX_ETH_FRAME))
                   && (txr_size[1:0] == 2'b00)
                   && (num_pkt != 32'd0);

    assign w_beats_exp = (txr_size + 16'(c_BYTES - 1)) / 16'(c_BYTES);

    assign w_acc = tx_valid & r_tx_ready;

    // Lanes past the configured packet size carry don't-care filler.
    for (genvar j = 0; j < c_LANES; j++) begin : g_lane
        logic [15:0] w_idx;
        assign w_idx = (r_beat * c_LANES16) + 16'(j);
        assign w_lane_err[j] = ({w_idx, 2'b00} < {2'b00, r_txr_size})
                            && (tx_data[32*j +: 32] != {r_pkt_idx, w_idx});
    end

    assign w_qid_err   = (r_beat == 16'd0) && (tx_qid != QID_W'(r_qid + r_q_off));
    assign w_short     = tx_last && (r_beat < r_last_beat);
    assign w_long      = !tx_last && (r_beat == r_last_beat);
    assign w_beat_errs = r_discard ? 4'b0000
                                   : {w_qid_err, w_long, w_short, |w_lane_err};
    assign w_pkt_bad   = r_pkt_err || (w_beat_errs != 4'b0000);
    assign w_pkt_next  = sat_inc(r_pkt_count);
    assign w_q_off_inc = r_q_off + QID_W'(1);

    always_ff @(posedge axi_aclk) begin
        if (axi_areset || w_clear) begin
            r_state     <= S_IDLE;
            r_tx_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pkt_count <= 32'd0;
            r_err_count <= 32'd0;
            r_err_flags <= 4'b0000;
            r_cycles    <= 32'd0;
            r_started   <= 1'b0;
            r_txr_size  <= 16'd0;
            r_last_beat <= 16'd0;
            r_num_pkt   <= 32'd0;
            r_qid       <= '0;
            r_num_queue <= '0;
            r_beat      <= 16'd0;
            r_discard   <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_pkt_idx   <= 16'd0;
            r_q_off     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start && w_cfg_ok) begin
                        r_state     <= S_RUN;
                        r_tx_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pkt_count <= 32'd0;
                        r_err_count <= 32'd0;
                        r_err_flags <= 4'b0000;
                        r_cycles    <= 32'd0;
                        r_started   <= 1'b0;
                        r_txr_size  <= txr_size;
                        r_last_beat <= w_beats_exp - 16'd1;
                        r_num_pkt   <= num_pkt;
                        r_qid       <= qid;
                        r_num_queue <= (num_queue == '0) ? QID_W'(1) : num_queue;
                        r_beat      <= 16'd0;
                        r_discard   <= 1'b0;
                        r_pkt_err   <= 1'b0;
                        r_pkt_idx   <= 16'd0;
                        r_q_off     <= '0;
                    end
                end
                S_RUN: begin
                    if (r_started || w_acc) begin
                        r_cycles <= sat_inc(r_cycles);
                    end
                    if (w_acc) begin
                        r_started   <= 1'b1;
                        r_err_flags <= r_err_flags | w_beat_errs;
                        // Any accepted last closes the packet, including one that ends a discard tail.
                        if (tx_last) begin
                            r_pkt_count <= w_pkt_next;
                            if (w_pkt_bad) begin
                                r_err_count <= sat_inc(r_err_count);
                            end
                            r_pkt_idx <= r_pkt_idx + 16'd1;
                            r_q_off   <= (w_q_off_inc == r_num_queue) ? '0 : w_q_off_inc;
                            r_beat    <= 16'd0;
                            r_discard <= 1'b0;
                            r_pkt_err <= 1'b0;
                            if (w_pkt_next == r_num_pkt) begin
                                r_state    <= S_DONE;
                                r_tx_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end
                        end else begin
                            r_pkt_err <= w_pkt_bad;
                            if (!r_discard) begin
                                if (w_long) begin
                                    r_discard <= 1'b1;
                                end else begin
                                    r_beat <= r_beat + 16'd1;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!w_start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready     = r_tx_ready;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pkt_count    = r_pkt_count;
    assign err_count    = r_err_count;
    assign err_flags    = r_err_flags;
    assign cycles_taken = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_traffic_chk.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_traffic_chk
// Description : Randomised self-checking bench for traffic_chk with a
//               packet-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_chk;

    localparam int TX_LEN = 512;
    localparam int QID_W  = 11;
    localparam int LANES  = TX_LEN / 32;
    localparam int BYTES  = TX_LEN / 8;

    logic              axi_aclk = 1'b0;
    logic              axi_areset;
    logic [31:0]       control_reg;
    logic [15:0]       txr_size;
    logic [31:0]       num_pkt;
    logic [QID_W-1:0]  qid;
    logic [QID_W-1:0]  num_queue;
    logic              tx_valid;
    logic              tx_ready;
    logic [TX_LEN-1:0] tx_data;
    logic              tx_last;
    logic [QID_W-1:0]  tx_qid;
    logic              busy;
    logic              done;
    logic [31:0]       pkt_count;
    logic [31:0]       err_count;
    logic [3:0]        err_flags;
    logic [31:0]       cycles_taken;

    traffic_chk #(.TX_LEN(TX_LEN), .MAX_ETH_FRAME(4096), .QID_W(QID_W)) dut (
        .axi_aclk     (axi_aclk),
        .axi_areset   (axi_areset),
        .control_reg  (control_reg),
        .txr_size     (txr_size),
        .num_pkt      (num_pkt),
        .qid          (qid),
        .num_queue    (num_queue),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_qid       (tx_qid),
        .busy         (busy),
        .done         (done),
        .pkt_count    (pkt_count),
        .err_count    (err_count),
        .err_flags    (err_flags),
        .cycles_taken (cycles_taken)
    );

    always #5 axi_aclk = ~axi_aclk;

    int cyc = 0;
    always @(posedge axi_aclk) cyc++;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: one run, tracked per packet.
    int        m_size, m_beats_exp, m_nq, m_qid, m_npkt;
    int        m_pkt, m_pkt_count, m_err_count;
    logic [3:0] m_flags;
    bit        m_started;
    int        m_first, m_last;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int p, input int idx);
        logic [31:0] pv;
        logic [31:0] iv;
        pv = p;
        iv = idx;
        return {pv[15:0], iv[15:0]};
    endfunction

    function automatic logic [QID_W-1:0] q_exp(input int p);
        return QID_W'(m_qid + (p % m_nq));
    endfunction

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic abort(input string tag);
        check_val(tag, 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "bench aborted");
    endtask

    // Sends one packet of nbeats beats; corrupts lane cl of beat cb when cb >= 0.
    task automatic send_pkt(input int nbeats, input logic [QID_W-1:0] q, input int cb,
                            input int cl, input int gap, input bit with_last);
        bit          d_err;
        bit          acc;
        int          idx;
        int          to;
        logic [31:0] w;
        logic [3:0]  f;
        d_err = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            for (int g = 0; g < gap; g++) begin
                tx_valid = 1'b0;
                tick();
            end
            for (int j = 0; j < LANES; j++) begin
                idx = k * LANES + j;
                if (idx * 4 < m_size) w = pat(m_pkt, idx);
                else                  w = $urandom;
                if (k == cb && j == cl) begin
                    w = w ^ (32'h1 << $urandom_range(0, 31));
                    if (idx * 4 < m_size && k < m_beats_exp) d_err = 1'b1;
                end
                tx_data[32*j +: 32] = w;
            end
            tx_valid = 1'b1;
            tx_last  = with_last && (k == nbeats - 1);
            tx_qid   = (k == 0) ? q : QID_W'($urandom);
            acc = 1'b0;
            to  = 0;
            while (!acc) begin
                @(negedge axi_aclk);
                acc = tx_ready;
                if (!acc) begin
                    to++;
                    if (to > 200) abort("ready_timeout");
                end
                @(posedge axi_aclk);
                #1;
            end
            if (!m_started) begin
                m_started = 1'b1;
                m_first   = cyc;
            end
            m_last = cyc;
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        if (with_last) begin
            f = {q != q_exp(m_pkt), nbeats > m_beats_exp, nbeats < m_beats_exp, d_err};
            m_flags = m_flags | f;
            if (f != 4'b0000) m_err_count++;
            m_pkt_count++;
            m_pkt++;
        end
    endtask

    task automatic run_cfg(input int size, input int npkt, input int nq, input int qb);
        int to;
        txr_size    = 16'(size);
        num_pkt     = 32'(npkt);
        num_queue   = QID_W'(nq);
        qid         = QID_W'(qb);
        m_size      = size;
        m_beats_exp = (size + BYTES - 1) / BYTES;
        m_nq        = (nq == 0) ? 1 : nq;
        m_qid       = qb;
        m_npkt      = npkt;
        m_pkt       = 0;
        m_pkt_count = 0;
        m_err_count = 0;
        m_flags     = 4'b0000;
        m_started   = 1'b0;
        control_reg = 32'd1;
        to = 0;
        while (!busy) begin
            tick();
            to++;
            if (to > 10) abort("start_timeout");
        end
        check_val("run_ready", {31'd0, tx_ready}, 32'd1);
        check_val("run_pkt_clr", pkt_count, 32'd0);
        // Config must be latched at RUN entry; disturb the live inputs.
        txr_size  = 16'($urandom);
        num_pkt   = $urandom;
        qid       = QID_W'($urandom);
        num_queue = QID_W'($urandom);
    endtask

    task automatic finish_run(input string tag);
        check_val({tag, "_done"},  {31'd0, done}, 32'd1);
        check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_val({tag, "_ready"}, {31'd0, tx_ready}, 32'd0);
        check_val({tag, "_pkts"},  pkt_count, 32'(m_pkt_count));
        check_val({tag, "_errs"},  err_count, 32'(m_err_count));
        check_val({tag, "_flags"}, {28'd0, err_flags}, {28'd0, m_flags});
        check_val({tag, "_cycles"}, cycles_taken, 32'(m_last - m_first + 1));
        control_reg = 32'd0;
        tick();
        check_val({tag, "_idle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #900000;
        abort("watchdog");
    end

    initial begin
        int be, nb, cb, mode;
        logic [QID_W-1:0] q;

        axi_areset  = 1'b1;
        control_reg = 32'd0;
        txr_size    = 16'd256;
        num_pkt     = 32'd8;
        qid         = '0;
        num_queue   = QID_W'(4);
        tx_valid    = 1'b0;
        tx_data     = '0;
        tx_last     = 1'b0;
        tx_qid      = '0;
        repeat (3) tick();
        axi_areset = 1'b0;
        tick();
        check_val("rst_ready",  {31'd0, tx_ready}, 32'd0);
        check_val("rst_busy",   {31'd0, busy}, 32'd0);
        check_val("rst_done",   {31'd0, done}, 32'd0);
        check_val("rst_pkts",   pkt_count, 32'd0);
        check_val("rst_errs",   err_count, 32'd0);
        check_val("rst_flags",  {28'd0, err_flags}, 32'd0);
        check_val("rst_cycles", cycles_taken, 32'd0);

        // clear outranks start
        control_reg = 32'd3;
        repeat (3) tick();
        check_val("clr_prio_busy", {31'd0, busy}, 32'd0);
        control_reg = 32'd0;
        tick();

        // 1: clean run
        run_cfg(256, 8, 4, 0);
        for (int p = 0; p < 8; p++) send_pkt(4, q_exp(p), -1, 0, 0, 1'b1);
        check_val("t1_cycles32", cycles_taken, 32'd32);
        finish_run("t1");

        // 2: one corrupted lane
        run_cfg(256, 8, 4, 0);
        for (int p = 0; p < 8; p++) send_pkt(4, q_exp(p), (p == 3) ? 1 : -1, 5, 0, 1'b1);
        check_val("t2_flags_fixed", {28'd0, err_flags}, 32'd1);
        finish_run("t2");

        // 3: short and long packets
        run_cfg(256, 8, 4, 0);
        for (int p = 0; p < 8; p++)
            send_pkt((p == 2) ? 3 : (p == 4) ? 6 : 4, q_exp(p), -1, 0, 0, 1'b1);
        check_val("t3_flags_fixed", {28'd0, err_flags}, 32'd6);
        finish_run("t3");

        // 4: partial last beat, wrong qid on packet 0
        run_cfg(100, 2, 1, 0);
        send_pkt(2, QID_W'(5), 1, 27, 0, 1'b1);
        send_pkt(2, q_exp(1), -1, 0, 0, 1'b1);
        check_val("t4_flags_fixed", {28'd0, err_flags}, 32'd8);
        finish_run("t4");

        // 5: valid one cycle in three
        run_cfg(256, 8, 4, 0);
        for (int p = 0; p < 8; p++) send_pkt(4, q_exp(p), -1, 0, 2, 1'b1);
        finish_run("t5");

        // 6: clear mid packet 3, then illegal configurations
        run_cfg(256, 8, 4, 0);
        for (int p = 0; p < 3; p++) send_pkt(4, q_exp(p), -1, 0, 0, 1'b1);
        send_pkt(2, q_exp(3), -1, 0, 0, 1'b0);
        control_reg = 32'd2;
        tick();
        check_val("t6_ready",  {31'd0, tx_ready}, 32'd0);
        check_val("t6_busy",   {31'd0, busy}, 32'd0);
        check_val("t6_pkts",   pkt_count, 32'd0);
        check_val("t6_errs",   err_count, 32'd0);
        check_val("t6_flags",  {28'd0, err_flags}, 32'd0);
        check_val("t6_cycles", cycles_taken, 32'd0);
        control_reg = 32'd0;
        tick();
        for (int i = 0; i < 6; i++) begin
            txr_size = (i == 0) ? 16'd4097 : (i == 1) ? 16'd4100 : (i == 2) ? 16'd0 :
                       (i == 3) ? 16'd6 : (i == 4) ? 16'd258 : 16'd256;
            num_pkt  = (i == 5) ? 32'd0 : 32'd8;
            control_reg = 32'd1;
            repeat (3) tick();
            check_val("badcfg_busy",  {31'd0, busy}, 32'd0);
            check_val("badcfg_ready", {31'd0, tx_ready}, 32'd0);
            control_reg = 32'd0;
            tick();
        end

        // Random runs
        for (int r = 0; r < 6; r++) begin
            run_cfg((r == 0) ? 4096 : 4 * $urandom_range(1, 1024), $urandom_range(1, 5),
                    $urandom_range(0, 5), (r == 1) ? 2046 : $urandom_range(0, 2047));
            be = m_beats_exp;
            for (int p = 0; p < m_npkt; p++) begin
                mode = $urandom_range(0, 9);
                if (mode == 0 && be > 1)  nb = $urandom_range(1, be - 1);
                else if (mode == 1)       nb = be + $urandom_range(1, 3);
                else                      nb = be;
                q  = q_exp(p);
                if ($urandom_range(0, 7) == 0) q = q ^ QID_W'($urandom_range(1, 2047));
                cb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
                send_pkt(nb, q, cb, $urandom_range(0, LANES - 1), $urandom_range(0, 1), 1'b1);
            end
            finish_run("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
